tone_wave_generator: RTL



---
 rtl/tone_wave_generator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tone_wave_generator.sv
// Tone synthesiser: plays a fixed-length note at F_CLK/256/prescale and emits
// signed PCM samples (square, triangle, sawtooth or silence) on a free-running sample strobe.
module tone_wave_generator #(
  parameter int          PRESCALE_W = 10,
  parameter int          DUR_CYCLES = 3_937_500,
  parameter logic [15:0] AMPLITUDE  = 16'h2000,
  parameter int          SAMPLE_DIV = 656
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] preScaleValue,
  input  logic                  enabler,
  input  logic [1:0]            wave_sel,
  output logic signed [15:0]    audio_sample,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int DUR_W = $clog2(DUR_CYCLES + 1);
  localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DUR_W-1:0]      DUR_LOAD  = DUR_W'(DUR_CYCLES - 1);
  localparam logic [DUR_W-1:0]      DUR_ONE   = DUR_W'(1);
  localparam logic [SMP_W-1:0]      SMP_LAST  = SMP_W'(SAMPLE_DIV - 1);
  localparam logic [SMP_W-1:0]      SMP_ONE   = SMP_W'(1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [0:0]            state;
  logic [PRESCALE_W-1:0] presc_lat;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [DUR_W-1:0]      dur_cnt;
  logic [7:0]            phase;
  logic [SMP_W-1:0]      smp_cnt;
  logic                  req;
  logic                  smp_tc;
  logic signed [15:0]    wave_p0;

  // Clamp the 25-bit intermediate into the 16-bit PCM range.
  function automatic logic signed [15:0] sat16(input logic signed [24:0] x);
    logic signed [15:0] r;
    if (x > 25'sd32767)
      r = 16'sh7FFF;
    else if (x < -25'sd32768)
      r = 16'sh8000;
    else
      r = $signed(x[15:0]);
    return r;
  endfunction

  function automatic logic signed [24:0] wave_calc(input logic [1:0] sel, input logic [7:0] p);
    logic signed [24:0] amp;
    logic signed [24:0] ramp;
    logic [6:0]         t;
    logic signed [24:0] r;
    amp  = $signed({9'b0, AMPLITUDE});
    ramp = '0;
    t    = '0;
    r    = '0;
    case (sel)
      2'b00: r = p[7] ? -amp : amp;
      2'b01: begin
        t    = p[7] ? ~p[6:0] : p[6:0];
        ramp = $signed({17'b0, t, 1'b0}) - 25'sd127;
        r    = (ramp * amp) >>> 7;
      end
      2'b10: begin
        ramp = $signed({17'b0, p}) - 25'sd128;
        r    = (ramp * amp) >>> 7;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req    = enabler && (preScaleValue != '0);
  assign smp_tc = (smp_cnt == SMP_LAST);

  always_comb begin
    wave_p0 = '0;
    if (state == ST_PLAY)
      wave_p0 = sat16(wave_calc(wave_sel, phase));
  end

  // Note control: a valid request (re)starts the note; phase survives a retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      presc_lat <= '0;
      presc_cnt <= '0;
      dur_cnt   <= '0;
      phase     <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state == ST_PLAY);
      case (state)
        ST_IDLE: begin
          if (req) begin
            state     <= ST_PLAY;
            presc_lat <= preScaleValue;
            dur_cnt   <= DUR_LOAD;
            presc_cnt <= '0;
            phase     <= '0;
          end
        end
        default: begin
          if (req) begin
            presc_lat <= preScaleValue;
            dur_cnt   <= DUR_LOAD;
            presc_cnt <= '0;
          end else begin
            if (dur_cnt == '0)
              state <= ST_IDLE;
            else
              dur_cnt <= dur_cnt - DUR_ONE;
            if (presc_cnt == presc_lat - PRESC_ONE) begin
              presc_cnt <= '0;
              phase     <= phase + 8'd1;
            end else begin
              presc_cnt <= presc_cnt + PRESC_ONE;
            end
          end
        end
      endcase
    end
  end

  // Sample stage: capture the waveform on terminal count, strobe valid with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_cnt      <= '0;
      sample_valid <= 1'b0;
      audio_sample <= '0;
    end else begin
      smp_cnt      <= smp_tc ? '0 : smp_cnt + SMP_ONE;
      sample_valid <= smp_tc;
      if (smp_tc)
        audio_sample <= wave_p0;
    end
  end

endmodule
